icache_dm: RTL
==============

# icache_dm

Direct-mapped, read-only instruction cache that sits between the fetch stage and the backing instruction memory, replacing the flat instruction array. It serves hits one cycle after request acceptance. On a miss it refills a whole block from memory over a valid/ready request channel and a beat-per-cycle data channel, then replays the lookup. All geometry is parametrised.

## Interface
- DATA_WIDTH, 32, instruction word width in bits (power of two, ≥ 8)
- ADDR_WIDTH, 64, byte-address width
- BLOCK_WORDS, 16, words per cache line (power of two, ≥ 2)
- N_SETS, 64, number of lines (power of two, ≥ 2)
- i_clk  in  1  clock, all state on rising edge
- i_arst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  fetch request valid
- i_req_addr  in  ADDR_WIDTH  fetch byte address; sub-word bits ignored
- o_req_ready  out  1  cache can accept a request this cycle
- o_instr_valid  out  1  o_instr holds the response, one-cycle pulse per request
- o_instr  out  DATA_WIDTH  fetched instruction word
- i_flush  in  1  invalidate all lines (e.g. fence.i), single-cycle pulse
- o_mem_req_valid  out  1  block refill request
- o_mem_req_addr  out  ADDR_WIDTH  block-aligned refill address
- i_mem_req_ready  in  1  memory accepts the refill request
- i_mem_data_valid  in  1  refill beat valid; the cache always accepts it
- i_mem_data  in  DATA_WIDTH  refill beat, words in ascending address order
- o_hit_count  out  32  hit counter (see Configuration)
- o_miss_count  out  32  miss counter (see Configuration)

## Operation
- Address split: byte-offset bits log2(DATA_WIDTH/8), word bits log2(BLOCK_WORDS), index log2(N_SETS), remainder is the tag.
- Storage: data array N_SETS×BLOCK_WORDS words, tag array, and one valid bit per line. Only the valid bits are reset.
- FSM states: IDLE, COMPARE, REFILL_REQ, REFILL_DATA.
  - IDLE: o_req_ready=1. A request is accepted on i_req_valid; its address is registered, then -> COMPARE.
  - COMPARE, hit: o_instr_valid=1 with the word. o_req_ready=1, so a new request may be accepted in the same cycle (stay COMPARE) or the FSM returns to IDLE.
  - COMPARE, miss: o_req_ready=0, the line's valid bit is cleared, -> REFILL_REQ.
  - REFILL_REQ: o_mem_req_valid=1, o_mem_req_addr = request address with word/byte offset zeroed. Held stable until i_mem_req_ready, then -> REFILL_DATA.
  - REFILL_DATA: a beat counter 0..BLOCK_WORDS-1 writes each valid beat into the line. Gaps in i_mem_data_valid are allowed. After the last beat the tag is written, valid is set, and the FSM -> COMPARE to replay (guaranteed hit).
- Flush: i_flush sets a pending bit in any state. The pending bit clears all valid bits on the next cycle the FSM is in IDLE or COMPARE, and that cycle has no hit (forced miss). A flush and a request in the same IDLE cycle: the request is accepted and sees the flushed state.
- Reset, including mid-refill: FSM -> IDLE, all valid bits=0, flush-pending=0. An in-flight refill is abandoned. The memory side must be reset together with the cache.

## Timing
- Reset values: o_req_ready=1, o_instr_valid=0, o_instr=0, o_mem_req_valid=0, o_mem_req_addr=0, counters=0.
- Hit latency: 1 cycle from acceptance. Back-to-back hits give 1 instruction/cycle.
- Miss latency: 1 (COMPARE) + request wait + BLOCK_WORDS beats + 1 (replay) cycles minimum, i.e. BLOCK_WORDS+3 with immediate ready and no beat gaps.
- o_instr is held between responses; it is valid only while o_instr_valid is high.

## Configuration
- ICACHE_PERF_EN defined: o_hit_count increments on each COMPARE hit. o_miss_count increments on each COMPARE miss. A replay hit counts as a hit. Both saturate at 2^32-1 and reset to 0.
- ICACHE_PERF_EN undefined: no counter logic; both outputs are tied to 0.

## Test plan
Bench geometry: BLOCK_WORDS=4, N_SETS=4, DATA_WIDTH=32; memory returns word = byte address.
- Reset, request 0x40 -> miss; o_mem_req_addr=0x40, 4 beats; o_instr=0x40 at cycle 7 after acceptance; o_miss_count=1, o_hit_count=1.
- Then requests 0x44, 0x48, 0x4C back-to-back -> three consecutive o_instr_valid cycles returning 0x44, 0x48, 0x4C; no memory request.
- Request 0x140 (same index as 0x40, different tag) -> refill; then 0x40 -> misses again (eviction).
- Random gaps in i_mem_data_valid and 3-cycle i_mem_req_ready delay -> o_mem_req_addr stable throughout; correct words returned.
- i_flush during REFILL_DATA -> the refill completes and the replay returns data, but the line is invalid afterwards; the next access to it misses.
- Assert i_arst mid-refill -> o_mem_req_valid=0 and o_req_ready=1 immediately; the next request to the same address misses.

Source files
------------

// File: rtl/icache_dm.sv
// ---------------------------------------------------------------------------
// icache_dm -- direct-mapped, read-only instruction cache
//
// Sits between the fetch stage and the backing instruction memory. A hit is
// answered in the cycle after the request is accepted. A miss refills the
// whole line over a valid/ready request channel plus a beat-per-cycle data
// channel, then replays the lookup, which is then guaranteed to hit.
//
// Parameters
//   DATA_WIDTH   instruction word width in bits (power of two, >= 8)
//   ADDR_WIDTH   byte-address width
//   BLOCK_WORDS  words per line (power of two, >= 2)
//   N_SETS       number of lines (power of two, >= 2)
//
// Ports
//   i_clk, i_arst        clock (rising edge) / asynchronous active-high reset
//   i_req_valid          fetch request valid
//   i_req_addr           fetch byte address (sub-word bits ignored)
//   o_req_ready          a request can be accepted this cycle
//   o_instr_valid        one-cycle pulse: o_instr holds the response
//   o_instr              fetched word, held between responses
//   i_flush              single-cycle pulse invalidating every line
//   o_mem_req_valid      refill request to memory
//   o_mem_req_addr       block-aligned refill address
//   i_mem_req_ready      memory accepts the refill request
//   i_mem_data_valid     refill beat valid (always accepted)
//   i_mem_data           refill beat, ascending word order
//   o_hit_count          saturating hit counter
//   o_miss_count         saturating miss counter
//
// Configuration macro
//   ICACHE_PERF_EN       defined: hit/miss counters are built.
//                        undefined: both counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module icache_dm #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WORDS = 16,
    parameter int N_SETS      = 64
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  o_req_ready,
    output logic                  o_instr_valid,
    output logic [DATA_WIDTH-1:0] o_instr,
    input  logic                  i_flush,
    output logic                  o_mem_req_valid,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    input  logic                  i_mem_req_ready,
    input  logic                  i_mem_data_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic [31:0]           o_hit_count,
    output logic [31:0]           o_miss_count
);

    localparam int OFF_BITS  = $clog2(DATA_WIDTH / 8);
    localparam int WORD_BITS = $clog2(BLOCK_WORDS);
    localparam int IDX_BITS  = $clog2(N_SETS);
    localparam int IDX_LO    = OFF_BITS + WORD_BITS;
    localparam int TAG_LO    = IDX_LO + IDX_BITS;
    localparam int TAG_BITS  = ADDR_WIDTH - TAG_LO;
    localparam int LINE_BYTES = BLOCK_WORDS * (DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_OFF_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [WORD_BITS-1:0]  LAST_BEAT     = WORD_BITS'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        REFILL_REQ,
        REFILL_DATA
    } state_t;

    state_t                          r_state;
    state_t                          w_nextState;
    logic [ADDR_WIDTH-1:0]           r_addr;
    logic [N_SETS-1:0]               r_valid;
    logic [TAG_BITS-1:0]             r_tags [N_SETS];
    logic [DATA_WIDTH-1:0]           r_data [N_SETS*BLOCK_WORDS];
    logic [WORD_BITS-1:0]            r_beat;
    logic                            r_flushPend;
    logic                            r_replay;
    logic [DATA_WIDTH-1:0]           r_instrHold;

    logic [IDX_BITS-1:0]             w_idx;
    logic [WORD_BITS-1:0]            w_word;
    logic [TAG_BITS-1:0]             w_tag;
    logic [DATA_WIDTH-1:0]           w_readWord;
    logic                            w_lineHit;
    logic                            w_hit;
    logic                            w_miss;
    logic                            w_accept;
    logic                            w_flushApply;
    logic                            w_beatWrite;
    logic                            w_fillDone;

    // Field extraction from the registered request address. Using +: keeps
    // the slices legal even when a field has zero byte-offset bits.
    assign w_idx      = r_addr[IDX_LO +: IDX_BITS];
    assign w_word     = r_addr[OFF_BITS +: WORD_BITS];
    assign w_tag      = r_addr[TAG_LO +: TAG_BITS];
    assign w_readWord = r_data[{w_idx, w_word}];
    assign w_lineHit  = r_valid[w_idx] && (r_tags[w_idx] == w_tag);

    // The refill address is the request with its word and byte offset
    // cleared. r_addr only changes on acceptance, so it stays stable for
    // the whole request handshake.
    assign o_mem_req_addr = r_addr & ~LINE_OFF_MASK;

    // The response word is driven straight from the array during a hit and
    // otherwise the last delivered word is held.
    assign o_instr_valid = w_hit;
    assign o_instr       = w_hit ? w_readWord : r_instrHold;

    // State register of the controller.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake decode. A pending flush turns a normal
    // lookup into a forced miss, but a replay right after a refill still
    // delivers its word: the refilled data is correct for that fetch even
    // though the flush wipes the line straight afterwards.
    always_comb begin
        w_nextState     = r_state;
        o_req_ready     = 1'b0;
        o_mem_req_valid = 1'b0;
        w_accept        = 1'b0;
        w_hit           = 1'b0;
        w_miss          = 1'b0;
        w_flushApply    = 1'b0;
        w_beatWrite     = 1'b0;
        w_fillDone      = 1'b0;
        case (r_state)
            IDLE: begin
                o_req_ready  = 1'b1;
                w_flushApply = r_flushPend;
                if (i_req_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = COMPARE;
                end
            end
            COMPARE: begin
                w_flushApply = r_flushPend;
                if (w_lineHit && (!r_flushPend || r_replay)) begin
                    w_hit       = 1'b1;
                    o_req_ready = 1'b1;
                    if (i_req_valid) begin
                        w_accept = 1'b1;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else begin
                    w_miss      = 1'b1;
                    w_nextState = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    w_nextState = REFILL_DATA;
                end
            end
            REFILL_DATA: begin
                if (i_mem_data_valid) begin
                    w_beatWrite = 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        w_fillDone  = 1'b1;
                        w_nextState = COMPARE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Control state: request address, valid bits, beat counter, flush
    // pending flag and the replay marker. A new flush pulse wins over the
    // consumption of an older one so that no flush is ever lost.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_addr      <= '0;
            r_valid     <= '0;
            r_beat      <= '0;
            r_flushPend <= 1'b0;
            r_replay    <= 1'b0;
            r_instrHold <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= i_req_addr;
            end

            if (w_fillDone) begin
                r_replay <= 1'b1;
            end else if (w_accept) begin
                r_replay <= 1'b0;
            end

            if (i_flush) begin
                r_flushPend <= 1'b1;
            end else if (w_flushApply) begin
                r_flushPend <= 1'b0;
            end

            if (w_flushApply) begin
                r_valid <= '0;
            end else if (w_miss) begin
                r_valid[w_idx] <= 1'b0;
            end else if (w_fillDone) begin
                r_valid[w_idx] <= 1'b1;
            end

            if (w_miss) begin
                r_beat <= '0;
            end else if (w_beatWrite) begin
                r_beat <= r_beat + 1'b1;
            end

            if (w_hit) begin
                r_instrHold <= w_readWord;
            end
        end
    end

    // Data and tag storage carry no reset; only the valid bits decide
    // whether their contents are meaningful.
    always_ff @(posedge i_clk) begin
        if (w_beatWrite) begin
            r_data[{w_idx, r_beat}] <= i_mem_data;
        end
        if (w_fillDone) begin
            r_tags[w_idx] <= w_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] r_hitCount;
    logic [31:0] r_missCount;

    // Saturating performance counters; a replay after a refill counts as
    // a hit in addition to the miss that started the refill.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_hitCount  <= '0;
            r_missCount <= '0;
        end else begin
            if (w_hit && (r_hitCount != 32'hFFFF_FFFF)) begin
                r_hitCount <= r_hitCount + 32'd1;
            end
            if (w_miss && (r_missCount != 32'hFFFF_FFFF)) begin
                r_missCount <= r_missCount + 32'd1;
            end
        end
    end

    assign o_hit_count  = r_hitCount;
    assign o_miss_count = r_missCount;
`else
    assign o_hit_count  = 32'd0;
    assign o_miss_count = 32'd0;
`endif

endmodule
